// File: rtl/sweep_pkg.sv
// Shared definitions for the exhaustive-sweep sequencer: FSM states and
// signature register constants.
package sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam int unsigned SIG_W = 8;

  // Feedback taps on bits 7, 5, 4 and 3.
  localparam logic [SIG_W-1:0] TAP_MASK = 8'hB8;

endpackage

// File: rtl/sig_lfsr8.sv
// 8-bit response signature register: shift with tap-parity feedback, then
// XOR in the data word. Clear has priority over enable.
module sig_lfsr8
  import sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  logic fb;

  always_comb begin
    fb = ^(sig & TAP_MASK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], fb} ^ din;
    end
  end

endmodule

// File: rtl/sweep_sequencer.sv
// Walks a combinational datapath through every input vector, holding each for
// SETTLE cycles, and publishes each sampled response plus a running signature.
module sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned N_OUT  = 2,
  parameter int unsigned SETTLE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic [N_IN-1:0]       stim,
  input  logic [N_OUT-1:0]      resp,
  output logic                  busy,
  output logic                  done,
  output logic                  cap_valid,
  output logic [N_IN+N_OUT-1:0] cap_data,
  output logic [SIG_W-1:0]      signature
);

  localparam int unsigned       CNT_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]   STIM_LAST = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             go;
  logic             capture;
  logic             advance;
  logic             clr_stim;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The sample is registered on the last APPLY edge so that cap_valid,
  // cap_data and the updated signature are all visible during CAPTURE without
  // any combinational path from resp or abort.
  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    capture   = 1'b0;
    advance   = 1'b0;
    clr_stim  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_nxt = S_APPLY;
          go        = 1'b1;
        end
      end
      S_APPLY: begin
        if (abort) begin
          state_nxt = S_IDLE;
          clr_stim  = 1'b1;
        end else if (cnt == '0) begin
          state_nxt = S_CAPTURE;
          capture   = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (abort) begin
          state_nxt = S_IDLE;
          clr_stim  = 1'b1;
        end else if (stim == STIM_LAST) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_APPLY;
          advance   = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        clr_stim  = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
        clr_stim  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stim      <= '0;
      cnt       <= '0;
      cap_valid <= 1'b0;
      cap_data  <= '0;
    end else begin
      cap_valid <= capture;
      if (capture) begin
        cap_data <= {stim, resp};
      end
      if (go || clr_stim) begin
        stim <= '0;
      end else if (advance) begin
        stim <= stim + 1'b1;
      end
      if (go || advance) begin
        cnt <= CNT_LOAD;
      end else if (state == S_APPLY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_comb begin
    busy = (state == S_APPLY) || (state == S_CAPTURE);
    done = (state == S_DONE);
  end

  sig_lfsr8 u_sig (
    .clk (clk),
    .rst (rst),
    .clr (go),
    .en  (capture),
    .din (SIG_W'(resp)),
    .sig (signature)
  );

endmodule
